// File: rtl/hilo_unit.sv
// hilo_unit: owns the architectural HI/LO registers and sequences the
// downstream iterative multiply and divide engines for MULT/DIV, MFHI/MFLO
// and MTHI/MTLO instructions arriving from EX.
//
// Optional feature: define HILO_DIVZERO_BYPASS_EN to resolve DIV by zero
// locally (HI <= dividend, LO <= all-ones) without starting the engine.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             hilo_stall,
  output logic             eng_mul,
  output logic             eng_div,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             mul_stall,
  input  logic             div_stall,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo
);

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MFLO = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             run_first;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             idle_op;
  logic             div_bypass;
  logic             start_mul, start_div;
  logic             mul_done, div_done;

  // An instruction only acts while the unit is idle; otherwise it is stalled
  // and EX retries it unchanged.
  assign idle_op = op_valid && (state == IDLE);

`ifdef HILO_DIVZERO_BYPASS_EN
  assign div_bypass = (rt_data == '0);
`else
  assign div_bypass = 1'b0;
`endif

  assign start_mul = idle_op && (op_code == OP_MULT);
  assign start_div = idle_op && (op_code == OP_DIV) && !div_bypass;

  // The engine stall is still low on the first run cycle while it loads
  // operands, so completion is only recognised from the second cycle on.
  assign mul_done = (state == MUL_RUN) && !run_first && !mul_stall;
  assign div_done = (state == DIV_RUN) && !run_first && !div_stall;

  assign hilo_stall = op_valid && (state != IDLE) && (op_code <= 3'd5);
  assign rd_data    = (op_code == OP_MFLO) ? lo_r : hi_r;

  // Next-state logic for the engine sequencer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_mul)      state_nxt = MUL_RUN;
        else if (start_div) state_nxt = DIV_RUN;
      end
      MUL_RUN: if (mul_done) state_nxt = COMMIT;
      DIV_RUN: if (div_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, first-run-cycle flag and engine request levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_first <= 1'b0;
      eng_mul   <= 1'b0;
      eng_div   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      run_first <= (state == IDLE) && (state_nxt != IDLE);
      eng_mul   <= (state_nxt == MUL_RUN);
      eng_div   <= (state_nxt == DIV_RUN);
    end
  end

  // Operand registers: captured on MULT/DIV accept, frozen during the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_a <= '0;
      eng_b <= '0;
    end else if (start_mul || start_div) begin
      eng_a <= rs_data;
      eng_b <= rt_data;
    end
  end

  // HI/LO: direct moves and bypassed divides in IDLE, engine commits in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (mul_done) begin
      hi_r <= mul_hi;
      lo_r <= mul_lo;
    end else if (div_done) begin
      hi_r <= div_hi;
      lo_r <= div_lo;
    end else if (idle_op) begin
      if (op_code == OP_MTHI) hi_r <= rs_data;
      if (op_code == OP_MTLO) lo_r <= rs_data;
      if ((op_code == OP_DIV) && div_bypass) begin
        hi_r <= rs_data;
        lo_r <= '1;
      end
    end
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the architectural HI/LO registers and sequences the iterative multiply and divide engines that sit directly downstream of it.
- Accepts HI/LO-class instructions from EX: MULT, DIV, MFHI, MFLO, MTHI, MTLO.
- For MULT/DIV it drives operands and a held request level into the engines, then commits the engine result into HI/LO.
- Returns an EX stall only when an instruction depends on an in-flight operation.

Parameters:
- WIDTH, 32, operand / HI / LO width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  an HI/LO-class instruction is present in EX.
- op_code  input  3  0=MULT 1=DIV 2=MFHI 3=MFLO 4=MTHI 5=MTLO; 6,7 = no-op.
- rs_data  input  WIDTH  operand A: multiplier, dividend, or MTHI/MTLO data.
- rt_data  input  WIDTH  operand B: multiplicand or divisor.
- rd_data  output  WIDTH  MFHI/MFLO result, combinational from HI_r/LO_r.
- hilo_stall  output  1  hold EX this cycle.
- eng_mul  output  1  multiply engine request level.
- eng_div  output  1  divide engine request level.
- eng_a  output  WIDTH  registered operand A (to the engine's LO input).
- eng_b  output  WIDTH  registered operand B (multiplicand or divisor).
- mul_stall  input  1  multiply engine busy.
- div_stall  input  1  divide engine busy.
- mul_hi, mul_lo  input  WIDTH each  multiply engine result.
- div_hi, div_lo  input  WIDTH each  divide engine result (remainder, quotient).

Behaviour:
- Reset (async, rst=1): HI_r=0, LO_r=0, eng_a=0, eng_b=0, eng_mul=0, eng_div=0, state=IDLE. hilo_stall=0 and rd_data=0 follow combinationally.
- States are IDLE, MUL_RUN, DIV_RUN and COMMIT.
- IDLE:
  - MULT/DIV accepted with no stall. eng_a<=rs_data, eng_b<=rt_data; next state MUL_RUN or DIV_RUN.
  - MTHI/MTLO write HI_r/LO_r at the next edge.
  - MFHI/MFLO return HI_r/LO_r the same cycle.
- MUL_RUN / DIV_RUN:
  - The matching eng_* request is held at 1 and eng_a/eng_b are frozen.
  - The first run cycle is ignored for completion, because the engine's stall is low while it loads.
  - From the second run cycle on, the first cycle with the engine stall=0 latches the engine hi/lo into HI_r/LO_r; next state COMMIT.
  - Request is deasserted in COMMIT.
- COMMIT: one cycle with no request; the engine returns to its idle load state. Next state IDLE.
- hilo_stall = op_valid AND state!=IDLE AND op_code in 0..5.
  - Any HI/LO access or new MULT/DIV waits until IDLE.
  - MFHI issued at cycle 0 right after a MULT is released in the first IDLE cycle and reads the new HI.
- A stalled instruction is retried by EX unchanged; no state is consumed while stalled.
- op_code 6/7, or op_valid=0: no effect.
- Reset mid-operation: requests drop immediately and HI/LO clear. The engines see the request low and abandon the operation.
- Nominal latency MULT/DIV accept to HI/LO usable: 1 (load) + engine iterations (33) + 1 commit + 1 = about 36 cycles. The bench must not hard-code this; completion is defined only by the engine stall.
- Signed semantics come entirely from the engines; this block does no arithmetic.

Optional Feature:
- Macro HILO_DIVZERO_BYPASS_EN.
- Defined: DIV with rt_data==0 is not sent to the engine. At the next edge HI_r<=rs_data, LO_r<=all-ones, and state stays IDLE, so there is no stall.
- Undefined: divide-by-zero runs through the engine like any divide, and its engine-defined result is committed.

Test Plan:
- Reset asserted mid-MUL_RUN -> eng_mul=0 and HI_r=LO_r=0 in the same cycle; after release, MFHI returns 0 with hilo_stall=0.
- MULT rs=7 rt=0xFFFFFFFD, then MFHI/MFLO back-to-back:
  - hilo_stall=1 until COMMIT completes.
  - MFHI then returns 0xFFFFFFFF and MFLO returns 0xFFFFFFEB.
  - Exactly one eng_mul high interval.
- DIV rs=0xFFFFFFEF (-17) rt=5 -> LO=0xFFFFFFFD and HI=0xFFFFFFFE after div_stall falls; eng_div drops in COMMIT.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then MFHI/MFLO in IDLE -> values returned the cycle after the writes, with no stall.
- MULT issued, then a second MULT or DIV while busy -> the second is stalled and starts only after the first commits; HI/LO end with the second result.
- With HILO_DIVZERO_BYPASS_EN, DIV rs=0x55 rt=0 -> no eng_div pulse, HI=0x55, LO=0xFFFFFFFF next cycle, no stall.
- Without HILO_DIVZERO_BYPASS_EN, the same divide-by-zero runs through the engine.
